// File: rtl/pixel_data_parse_pkg.sv
// pixel_data_parse_pkg: MIPI pixel-link framing constants and parser states
package pixel_data_parse_pkg;
  localparam int WORD_W = 48;
  localparam logic [15:0] SOF = 16'hFFEA;
  localparam logic [7:0] EOF_B0 = 8'hAA;
  localparam logic [7:0] EOF_B1 = 8'hDD;
  localparam logic [7:0] PHL_ID = 8'h00;
  localparam logic [7:0] DTYPE = 8'h01;
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, PAYLOAD, TAIL, EOF_HI} state_t;
  // Header word carries the length big-endian from byte 1 upwards
  function automatic logic [WORD_W-1:0] hdr_word(input logic [31:0] len);
    return {PHL_ID, len[7:0], len[15:8], len[23:16], len[31:24], DTYPE};
  endfunction
endpackage

// File: rtl/pixel_data_parse.sv
// pixel_data_parse: receive-side pixel frame parser delivering a DLEN-byte payload
module pixel_data_parse
  import pixel_data_parse_pkg::*;
#(
  parameter int unsigned DLEN = 32'h002b
) (
  input  logic              rx_pixel_clk,
  input  logic              reset,
  input  logic [63:0]       pixel_value,
  input  logic              pixel_valid,
  output logic [DLEN*8-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              err_hdr,
  output logic              err_eof,
  output logic              err_sync
);
  localparam int NW = int'(DLEN / 6);
  localparam int REM = int'(DLEN % 6);
  localparam int NB = NW > 0 ? $clog2(NW + 1) : 1;
  localparam int CW = (NW + 1) * WORD_W;
  localparam logic [WORD_W-1:0] HDR = hdr_word(DLEN);
  state_t state, nxt;
  logic [NB-1:0] n;
  logic [CW-1:0] cap, cap_nx;
  logic [WORD_W-1:0] w;
  logic sof, done, e_hdr, e_eof, e_sync, clr_n, inc_n, unused_hi;
  assign w = pixel_value[WORD_W-1:0];
  assign unused_hi = ^pixel_value[63:WORD_W];
  assign sof = w[15:0] == SOF;
  assign busy = state != IDLE;
  // EOF lanes sit right after the REM trailing payload bytes; REM=5 pushes DD into the next word
  function automatic logic tail_ok(input logic [WORD_W-1:0] t);
    logic [63:0] x;
    x = {16'h0, t};
    return x[8*REM +: 8] == EOF_B0 && (REM == 5 || x[8*REM+8 +: 8] == EOF_B1);
  endfunction
  always_comb begin
    nxt = state;
    cap_nx = cap;
    done = 1'b0;
    e_hdr = 1'b0;
    e_eof = 1'b0;
    e_sync = 1'b0;
    clr_n = 1'b0;
    inc_n = 1'b0;
    if (pixel_valid) begin
      if (state inside {HDR2, PAYLOAD, TAIL, EOF_HI} && sof) begin
        nxt = HDR1;
        e_sync = 1'b1;
      end else begin
        case (state)
          IDLE: nxt = sof ? HDR1 : IDLE;
          HDR1: begin
            nxt = w == HDR ? HDR2 : IDLE;
            e_hdr = w != HDR;
          end
          HDR2: begin
            nxt = w != HDR ? IDLE : NW == 0 ? TAIL : PAYLOAD;
            e_hdr = w != HDR;
            clr_n = 1'b1;
          end
          PAYLOAD: begin
            cap_nx[int'(n)*WORD_W +: WORD_W] = w;
            inc_n = 1'b1;
            nxt = int'(n) + 1 == NW ? TAIL : PAYLOAD;
          end
          TAIL: begin
            cap_nx[NW*WORD_W +: WORD_W] = w;
            nxt = tail_ok(w) && REM == 5 ? EOF_HI : IDLE;
            done = tail_ok(w) && REM != 5;
            e_eof = !tail_ok(w);
          end
          EOF_HI: begin
            done = w[7:0] == EOF_B1;
            e_eof = w[7:0] != EOF_B1;
            nxt = IDLE;
          end
          default: nxt = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge rx_pixel_clk) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      data <= '0;
      data_valid <= 1'b0;
      err_hdr <= 1'b0;
      err_eof <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      state <= nxt;
      cap <= cap_nx;
      n <= clr_n ? '0 : inc_n ? n + 1'b1 : n;
      data_valid <= done;
      err_hdr <= e_hdr;
      err_eof <= e_eof;
      err_sync <= e_sync;
      if (done) data <= cap_nx[DLEN*8-1:0];
    end
  end
endmodule

// File: doc/pixel_data_parse.md
# pixel_data_parse

Receive-side frame parser for the MIPI pixel link. It consumes the 48-bit-per-clock pixel words produced by the transmit-side frame generator and recovers the framed payload. Frame layout: SOF word, two identical header words, payload words, EOF marker. It delivers the DLEN-byte payload as one wide register with a single-cycle valid strobe, and flags framing errors. It sits directly behind the MIPI RX pixel interface and feeds the miner's work-data input.

## Interface
- DLEN, 32'h002b: payload length in bytes; fixes the output width and the expected header length field.
- rx_pixel_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_value  in  64  received pixel word; only bits [47:0] are used; byte j of the word sits at [8j+7:8j].
- pixel_valid  in  1  pixel_value is meaningful this cycle; when low, the word is ignored and state holds.
- data  out  DLEN*8  last complete payload; payload byte i is at [8i+7:8i].
- data_valid  out  1  one-cycle pulse; data has just been updated.
- busy  out  1  a frame is in progress, from SOF accepted until completion or abort.
- err_hdr  out  1  one-cycle pulse: header mismatch, or bad PHL_ID, DTYPE or length field.
- err_eof  out  1  one-cycle pulse: EOF bytes missing or wrong.
- err_sync  out  1  one-cycle pulse: SOF received mid-frame.

## Operation
- Constants: SOF word has [15:0]=16'hFFEA, with [47:16] ignored. EOF bytes are 8'hAA then 8'hDD. PHL_ID=8'h00, DTYPE=8'h01.
- Derived values: NW = DLEN/6 full payload words; REM = DLEN%6.
- Header word layout:
  - [7:0] DTYPE
  - [15:8] LEN[31:24]
  - [23:16] LEN[23:16]
  - [31:24] LEN[15:8]
  - [39:32] LEN[7:0]
  - [47:40] PHL_ID
  - LEN must equal DLEN.
- States: IDLE, HDR1, HDR2, PAYLOAD, TAIL, EOF_HI. All transitions happen only on accepted words (pixel_valid=1).
- IDLE: a word matching SOF sets busy=1 and moves to HDR1. Any other word, including all-zero idle words, is ignored.
- HDR1: store the word. If PHL_ID, DTYPE or LEN is wrong, pulse err_hdr and go to IDLE. Otherwise go to HDR2.
- HDR2: the word must equal the stored header, else pulse err_hdr and go to IDLE. On a match, clear the word counter n and go to PAYLOAD. If NW=0, go to TAIL instead.
- PAYLOAD: write the word to capture buffer bytes 6n..6n+5 and increment n. When n reaches NW, go to TAIL.
- TAIL: the word's low REM bytes are payload bytes 6·NW..DLEN-1, followed by the EOF bytes.
  - REM 0..4: byte REM must be 8'hAA and byte REM+1 must be 8'hDD. Then complete.
  - REM=5: byte 5 must be 8'hAA. Then go to EOF_HI.
- EOF_HI: byte 0 must be 8'hDD. Then complete.
- Complete: copy the capture buffer to data, pulse data_valid, clear busy, go to IDLE.
- An EOF byte mismatch pulses err_eof and goes to IDLE. data keeps its old value.
- Any state other than IDLE/HDR1: a word whose [15:0] matches SOF pulses err_sync and restarts at HDR1 with busy held high. The check is skipped in HDR1 because the header word's low bytes can never equal 16'hFFEA when DTYPE=8'h01.
- Bytes above the EOF marker in the last word are ignored.
- An abort or error never changes data.

## Timing
- Reset values: state IDLE; data=0; data_valid, busy and all err_* = 0; capture buffer contents don't-care.
- Latency: data, data_valid and err_* are registered and assert the cycle after the deciding word is accepted.
- pixel_valid low stalls for any number of cycles with no timeout.
- Reset asserted mid-frame: the next cycle is in IDLE, busy=0, and no strobes are emitted.
- Back-to-back frames: an SOF accepted the cycle after completion is legal. data_valid and busy=1 are both seen for that frame.
- Throughput: one word per clock.

## Structure
- A shared package, also used by the transmit generator, holds:
  - SOF, EOF, PHL_ID and DTYPE constants
  - the word width (48)
  - the state enum
- No sub-module. The byte-lane compare for the EOF position is a local function of REM, resolved at elaboration.

## Test plan
- DLEN=43 (NW=7, REM=1), clean frame of 11 consecutive words:
  - FFEA; 002B00000001 twice; seven payload words with bytes 0..41 = 0x00..0x29; final word 0000_00DDAA2A.
  - Expected: data_valid pulses once, the cycle after word 11; data byte i = i; busy high from the cycle after SOF through completion.
- Same frame with pixel_valid low for 3 cycles between each word: identical data, with data_valid delayed accordingly.
- Second header word with LEN byte 2C: err_hdr pulse, busy drops, no data_valid, data unchanged.
- Final word with AA/DD swapped: err_eof pulse, data keeps the prior frame's value.
- SOF injected after 4 payload words, then a full clean frame follows: one err_sync pulse, then data_valid with the new payload.
- DLEN=47 (REM=5): last payload word carries bytes 42..46 plus AA in byte 5, and the next word is 0x..DD. data_valid asserts the cycle after the DD word. Reset asserted during PAYLOAD instead: no strobes, busy=0 the next cycle.
